// File: rtl/mst_tlp_sender_pkg.sv
// Shared definitions for the master-FIFO to PCIe TLP sender: FSM state
// encoding, FIFO word layout, TLP header size and credit granularity.
package mst_tlp_sender_pkg;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_WAIT_CRED,
        ST_REQ,
        ST_SEND,
        ST_GAP
    } state_e;

    // FIFO word layout: {start, end, data[15:0]}
    localparam int FIFO_W    = 18;
    localparam int WORD_W    = 16;
    localparam int START_BIT = 17;
    localparam int END_BIT   = 16;

    // A TLP carries a 3-word header; everything after it is payload,
    // and one posted-data credit covers 8 payload words.
    localparam int HDR_WORDS        = 3;
    localparam int WORDS_PER_CREDIT = 8;
    localparam int MIN_LEN          = HDR_WORDS + 1;

    // Posted-data credits needed for a record of len words (len >= MIN_LEN).
    function automatic logic [12:0] data_credits_needed(input logic [12:0] len);
        return (len - 13'(HDR_WORDS) + 13'(WORDS_PER_CREDIT - 1)) >> $clog2(WORDS_PER_CREDIT);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tlp_word_buf.sv
// One-record word buffer: 2^AW x DW RAM, one write port, one read port
// with a registered read (data appears the edge after the address).
module tlp_word_buf
    import mst_tlp_sender_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = WORD_W
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    // Write the incoming word and register the read word every cycle.
    // NOTE: the storage array has no reset; every word is written before it is read, and a reset would stop it mapping onto RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/mst_tlp_sender.sv
// Drains framed records from the master FIFO into a one-record buffer and
// streams each complete record to the PCIe core's 16-bit transmit port.
// Malformed, short or oversized records are dropped and counted.
// Build option: define MST_TLP_CREDIT_CHECK_EN to make WAIT_CRED wait for
// posted header/data credits; otherwise WAIT_CRED always advances in one cycle.
// GAP_CYCLES must be at least 1.
module mst_tlp_sender
    import mst_tlp_sender_pkg::*;
#(
    parameter int BUF_AW     = 5,
    parameter int GAP_CYCLES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [FIFO_W-1:0] mst_dout,
    input  logic              mst_empty,
    output logic              mst_rd_en,
    output logic              tx_req,
    input  logic              tx_rdy,
    output logic              tx_st,
    output logic              tx_end,
    output logic [WORD_W-1:0] tx_data,
    input  logic [8:0]        tx_ca_ph,
    input  logic [12:0]       tx_ca_pd,
    output logic [15:0]       tlp_count,
    output logic [7:0]        drop_count
);

    // Pointers and length carry one extra bit so a full buffer (32) is representable.
    localparam int            PW    = BUF_AW + 1;
    localparam logic [PW-1:0] DEPTH = PW'(2**BUF_AW);

    state_e            state_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     len_q;
    logic              in_rec_q;
    logic              rd_vld_q;
    logic              tx_req_q;
    logic              tx_st_q;
    logic              tx_end_q;
    logic [7:0]        gap_cnt_q;
    logic [15:0]       tlp_count_q;
    logic [7:0]        drop_count_q;

    logic              arrive;
    logic              word_st;
    logic              word_end;
    logic              wr_en;
    logic [BUF_AW-1:0] wr_addr;
    logic              rec_done;
    logic              drop_partial;
    logic              drop_ovf;
    logic              cred_ok;
    logic [12:0]       cred_need;
    logic [WORD_W-1:0] buf_rdata;

    // Decode the FIFO word returned this cycle into buffer-write and framing events.
    // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        arrive       = (state_q == ST_FILL) && rd_vld_q;
        word_st      = mst_dout[START_BIT];
        word_end     = mst_dout[END_BIT];
        wr_en        = 1'b0;
        wr_addr      = wr_ptr_q[BUF_AW-1:0];
        rec_done     = 1'b0;
        drop_partial = 1'b0;
        drop_ovf     = 1'b0;
        if (arrive) begin
            if (word_st) begin
                wr_en        = 1'b1;
                wr_addr      = '0;
                drop_partial = in_rec_q;
                rec_done     = word_end;
            end else if (in_rec_q) begin
                if (wr_ptr_q == DEPTH) begin
                    drop_ovf = 1'b1;
                end else begin
                    wr_en    = 1'b1;
                    rec_done = word_end;
                end
            end
        end
    end

    // The end word is the only word in flight when it lands, so pop is
    // suppressed in that cycle and no word beyond the record is fetched.
    assign mst_rd_en = sys_rst_n && (state_q == ST_FILL) && !mst_empty && !rec_done;

    assign cred_need = data_credits_needed(13'(len_q));

`ifdef MST_TLP_CREDIT_CHECK_EN
    assign cred_ok = (tx_ca_ph != '0) && (tx_ca_pd >= cred_need);
`else
    logic unused_cred;
    assign cred_ok     = 1'b1;
    assign unused_cred = ^{tx_ca_ph, tx_ca_pd, cred_need};
`endif

    // Record FSM: assemble, check credits, request the link, stream, then idle.
    // NOTE: state registers use non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= ST_FILL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            in_rec_q     <= 1'b0;
            rd_vld_q     <= 1'b0;
            tx_req_q     <= 1'b0;
            tx_st_q      <= 1'b0;
            tx_end_q     <= 1'b0;
            gap_cnt_q    <= '0;
            tlp_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            rd_vld_q <= mst_rd_en;
            tx_st_q  <= 1'b0;
            unique case (state_q)
                ST_FILL: begin
                    if (drop_partial || drop_ovf) begin
                        drop_count_q <= sat_inc8(drop_count_q);
                    end
                    if (arrive && word_st) begin
                        in_rec_q <= 1'b1;
                        wr_ptr_q <= PW'(1);
                    end else if (wr_en) begin
                        wr_ptr_q <= wr_ptr_q + PW'(1);
                    end
                    if (drop_ovf) begin
                        in_rec_q <= 1'b0;
                    end
                    if (rec_done) begin
                        in_rec_q <= 1'b0;
                        len_q    <= word_st ? PW'(1) : wr_ptr_q + PW'(1);
                        state_q  <= ST_WAIT_CRED;
                    end
                end
                ST_WAIT_CRED: begin
                    if (len_q < PW'(MIN_LEN)) begin
                        drop_count_q <= sat_inc8(drop_count_q);
                        state_q      <= ST_FILL;
                    end else if (cred_ok) begin
                        tx_req_q <= 1'b1;
                        rd_ptr_q <= '0;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Read address sits at 0 here, so word 0 is registered on the grant edge.
                    if (tx_rdy) begin
                        tx_req_q <= 1'b0;
                        tx_st_q  <= 1'b1;
                        tx_end_q <= (len_q == PW'(1));
                        rd_ptr_q <= rd_ptr_q + PW'(1);
                        state_q  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_end_q) begin
                        tx_end_q    <= 1'b0;
                        tlp_count_q <= tlp_count_q + 16'd1;
                        gap_cnt_q   <= '0;
                        state_q     <= ST_GAP;
                    end else begin
                        tx_end_q <= (rd_ptr_q == len_q - PW'(1));
                        rd_ptr_q <= rd_ptr_q + PW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 8'(GAP_CYCLES - 1)) begin
                        state_q <= ST_FILL;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 8'd1;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    tlp_word_buf #(
        .AW (BUF_AW),
        .DW (WORD_W)
    ) u_buf (
        .clk_i   (sys_clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (mst_dout[WORD_W-1:0]),
        .raddr_i (rd_ptr_q[BUF_AW-1:0]),
        .rdata_o (buf_rdata)
    );

    assign tx_req     = tx_req_q;
    assign tx_st      = tx_st_q;
    assign tx_end     = tx_end_q;
    assign tx_data    = (state_q == ST_SEND) ? buf_rdata : '0;
    assign tlp_count  = tlp_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_mst_tlp_sender.sv
// Directed bench for mst_tlp_sender: FIFO model, grant responder, link monitor.
module tb_mst_tlp_sender;

    localparam int GAP = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [17:0] mst_dout = '0;
    logic        mst_empty = 1'b1;
    logic        mst_rd_en;
    logic        tx_req;
    logic        tx_rdy = 1'b0;
    logic        tx_st;
    logic        tx_end;
    logic [15:0] tx_data;
    logic [8:0]  tx_ca_ph = 9'd4;
    logic [12:0] tx_ca_pd = 13'd40;
    logic [15:0] tlp_count;
    logic [7:0]  drop_count;

    mst_tlp_sender #(.BUF_AW(5), .GAP_CYCLES(GAP)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .mst_dout   (mst_dout),
        .mst_empty  (mst_empty),
        .mst_rd_en  (mst_rd_en),
        .tx_req     (tx_req),
        .tx_rdy     (tx_rdy),
        .tx_st      (tx_st),
        .tx_end     (tx_end),
        .tx_data    (tx_data),
        .tx_ca_ph   (tx_ca_ph),
        .tx_ca_pd   (tx_ca_pd),
        .tlp_count  (tlp_count),
        .drop_count (drop_count)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [17:0] fifo_q[$];
    logic [17:0] exp_q[$];
    logic [17:0] out_q[$];
    logic [17:0] pop_w;
    logic        rd_en_s = 1'b0;
    int cyc = 0;
    int rdy_dly = 3;
    int req_age = 0;
    int rdy_cyc = -1, st_cyc = -1, end_cyc = -1, req_rise_cyc = -1;
    int last_pop_cyc = -1, first_rd_cyc = -1;
    int pkts = 0, req_rises = 0;
    bit in_pkt = 0, req_prev = 0, gap_armed = 0;

    // FIFO model: registered read, data valid the cycle after the pop.
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (rd_en_s && fifo_q.size() > 0) begin
            pop_w = fifo_q.pop_front();
            mst_dout <= pop_w;
        end
        mst_empty <= (fifo_q.size() == 0);
    end

    // Link monitor and grant responder, sampled mid-cycle.
    always @(negedge sys_clk) begin
        rd_en_s = mst_rd_en;
        if (!sys_rst_n) begin
            in_pkt  = 0;
            req_age = 0;
            tx_rdy  = 1'b0;
            req_prev = 0;
        end else begin
            if (mst_rd_en) begin
                last_pop_cyc = cyc;
                if (gap_armed) begin
                    first_rd_cyc = cyc;
                    gap_armed = 0;
                end
            end
            if (tx_req && !req_prev) begin
                req_rise_cyc = cyc;
                req_rises++;
            end
            req_prev = tx_req;
            if (tx_rdy) begin
                tx_rdy = 1'b0;
            end else if (tx_req) begin
                req_age++;
                if (req_age >= rdy_dly) begin
                    tx_rdy  = 1'b1;
                    rdy_cyc = cyc;
                    req_age = 0;
                end
            end else begin
                req_age = 0;
            end
            if (tx_st) begin
                in_pkt = 1;
                st_cyc = cyc;
            end
            if (in_pkt || tx_end) out_q.push_back({tx_st, tx_end, tx_data});
            if (tx_end) begin
                in_pkt = 0;
                end_cyc = cyc;
                pkts++;
                gap_armed = 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        #1;
        out_q.delete();
        pkts = 0; req_rises = 0; gap_armed = 0;
        tx_ca_ph = 9'd4; tx_ca_pd = 13'd40;
        sys_rst_n = 1'b1;
    endtask

    task automatic push_raw(input bit s, input bit e, input logic [15:0] d);
        fifo_q.push_back({s, e, d});
    endtask

    // Record of n words: word 0 = start/90FF, word i = base+i, last carries end.
    task automatic push_rec(input int n, input logic [15:0] base, input bit sent);
        logic [17:0] w;
        for (int i = 0; i < n; i++) begin
            w = {(i == 0), (i == n - 1), (i == 0) ? 16'h90FF : base + 16'(i)};
            fifo_q.push_back(w);
            if (sent) exp_q.push_back(w);
        end
    endtask

    task automatic wait_pkts(input int n, input string tag);
        int budget = 400;
        while (pkts < n && budget > 0) begin
            @(negedge sys_clk); #1;
            budget--;
        end
        n_checks++;
        if (pkts < n) $display("FAIL %s timeout: packets=%0d required=%0d", tag, pkts, n);
        else n_pass++;
        repeat (3) @(negedge sys_clk);
        #1;
    endtask

    task automatic compare_stream(input string tag);
        n_checks++;
        if (out_q.size() !== exp_q.size())
            $display("FAIL %s length: got=%0d required=%0d", tag, out_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (out_q[i] !== exp_q[i])
                $display("FAIL %s word %0d: got=%h required=%h", tag, i, out_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic check_counts(input string tag, input int tlp, input int drp);
        n_checks++;
        if (tlp_count !== 16'(tlp)) $display("FAIL %s tlp_count: got=%0d required=%0d", tag, tlp_count, tlp);
        else n_pass++;
        n_checks++;
        if (drop_count !== 8'(drp)) $display("FAIL %s drop_count: got=%0d required=%0d", tag, drop_count, drp);
        else n_pass++;
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if ({mst_rd_en, tx_req, tx_st, tx_end, tx_data, tlp_count, drop_count} !== '0)
            $display("FAIL %s outputs: rd_en=%b req=%b st=%b end=%b data=%h tlp=%0d drop=%0d required all 0",
                     tag, mst_rd_en, tx_req, tx_st, tx_end, tx_data, tlp_count, drop_count);
        else n_pass++;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        push_raw(0, 0, 16'h1234);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk); #1;
        check_idle("reset");
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        #1;
        check_counts("orphan_word", 0, 0);
        n_checks++;
        if (req_rises !== 0) $display("FAIL orphan_word tx_req: got=%0d rises required=0", req_rises);
        else n_pass++;
    endtask

    task automatic test_normal();
        do_reset();
        push_rec(19, 16'hA000, 1);
        wait_pkts(1, "normal");
        compare_stream("normal");
        check_counts("normal", 1, 0);
        n_checks++;
        if (st_cyc !== rdy_cyc + 1) $display("FAIL normal st_timing: got=%0d required=%0d", st_cyc, rdy_cyc + 1);
        else n_pass++;
        n_checks++;
        if (req_rise_cyc !== last_pop_cyc + 3)
            $display("FAIL normal req_latency: got=%0d required=%0d", req_rise_cyc, last_pop_cyc + 3);
        else n_pass++;
    endtask

    task automatic test_credit_stall();
        int c;
        do_reset();
        tx_ca_pd = 13'd1;
        push_rec(19, 16'hB000, 1);
`ifdef MST_TLP_CREDIT_CHECK_EN
        repeat (60) @(negedge sys_clk);
        #1;
        n_checks++;
        if (req_rises !== 0) $display("FAIL credit_stall early_req: got=%0d rises required=0", req_rises);
        else n_pass++;
        c = cyc;
        tx_ca_pd = 13'd2;
        wait_pkts(1, "credit_stall");
        n_checks++;
        if (req_rise_cyc !== c + 1) $display("FAIL credit_stall req_cycle: got=%0d required=%0d", req_rise_cyc, c + 1);
        else n_pass++;
`else
        c = 0;
        wait_pkts(1, "credit_ignored");
        n_checks++;
        if (req_rise_cyc !== last_pop_cyc + 3 + c)
            $display("FAIL credit_ignored req_cycle: got=%0d required=%0d", req_rise_cyc, last_pop_cyc + 3);
        else n_pass++;
`endif
        compare_stream("credit");
        check_counts("credit", 1, 0);
    endtask

    task automatic test_restart();
        do_reset();
        push_raw(1, 0, 16'h90FF);
        for (int i = 0; i < 5; i++) push_raw(0, 0, 16'hDEAD);
        push_rec(19, 16'hC000, 1);
        wait_pkts(1, "restart");
        compare_stream("restart");
        check_counts("restart", 1, 1);
    endtask

    task automatic test_overflow();
        do_reset();
        push_raw(1, 0, 16'h90FF);
        for (int i = 0; i < 40; i++) push_raw(0, 0, 16'(16'hE000 + i));
        push_rec(19, 16'hD000, 1);
        wait_pkts(1, "overflow");
        compare_stream("overflow");
        check_counts("overflow", 1, 1);
    endtask

    task automatic test_short_records();
        do_reset();
        push_raw(1, 1, 16'h90FF);
        push_rec(3, 16'h3000, 0);
        push_rec(4, 16'h4000, 1);
        wait_pkts(1, "short");
        compare_stream("short");
        check_counts("short", 1, 2);
        n_checks++;
        if (req_rises !== 1) $display("FAIL short req_count: got=%0d required=1", req_rises);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int e;
        do_reset();
        push_rec(19, 16'h1000, 1);
        push_rec(19, 16'h2000, 1);
        wait_pkts(1, "b2b_first");
        e = end_cyc;
        wait_pkts(2, "b2b_second");
        compare_stream("b2b");
        check_counts("b2b", 2, 0);
        n_checks++;
        if (first_rd_cyc !== e + GAP + 1) $display("FAIL b2b gap: got=%0d required=%0d", first_rd_cyc, e + GAP + 1);
        else n_pass++;
        n_checks++;
        if (req_rise_cyc !== e + GAP + 19 + 3)
            $display("FAIL b2b next_req: got=%0d required=%0d", req_rise_cyc, e + GAP + 22);
        else n_pass++;
    endtask

    task automatic test_reset_in_send();
        int budget = 200;
        do_reset();
        push_rec(19, 16'h5000, 1);
        while (out_q.size() < 8 && budget > 0) begin
            @(negedge sys_clk); #1;
            budget--;
        end
        n_checks++;
        if (out_q.size() !== 8) $display("FAIL rst_send reach_word7: got=%0d words required=8", out_q.size());
        else n_pass++;
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        check_idle("rst_send");
        do_reset();
        push_rec(19, 16'h6000, 1);
        wait_pkts(1, "after_rst");
        compare_stream("after_rst");
        check_counts("after_rst", 1, 0);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_credit_stall();
        test_restart();
        test_overflow();
        test_short_records();
        test_back_to_back();
        test_reset_in_send();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
